mmio_bridge: RTL

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_bridge.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge
// Sits between a soft processor's data port and its data RAM.
// Addresses below MMIO_BASE go to RAM. Addresses from MMIO_BASE upward
// form a small I/O window:
//   - display-coordinate output channels (double-buffered or immediate)
//   - a keyboard byte FIFO with a sticky overflow flag
//   - a free-running frame counter
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous active-high reset
//   address_dmem processor data address
//   data         processor store data
//   wren         processor store strobe
//   rden         processor load strobe (one cycle per load)
//   q_dmem       load data, valid one cycle after rden
//   ram_wren     RAM write enable, gated to the RAM address range
//   ram_q        RAM read data (one-cycle latency)
//   key_valid    one-cycle pulse per received keyboard byte
//   key_data     received keyboard byte
//   frame_start  one-cycle pulse at start of vertical blanking
//   chan_out     visible channel values, channel i at [i*OUT_W +: OUT_W]
module mmio_bridge #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MMIO_BASE = 2000,
    parameter int NUM_OUT   = 4,
    parameter int OUT_W     = 10,
    parameter int KEY_DEPTH = 8,
    parameter int SHADOW    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address_dmem,
    input  logic [DATA_W-1:0]        data,
    input  logic                     wren,
    input  logic                     rden,
    output logic [DATA_W-1:0]        q_dmem,
    output logic                     ram_wren,
    input  logic [DATA_W-1:0]        ram_q,
    input  logic                     key_valid,
    input  logic [7:0]               key_data,
    input  logic                     frame_start,
    output logic [NUM_OUT*OUT_W-1:0] chan_out
);

    localparam int PTR_W = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] BASE        = 32'(MMIO_BASE);
    localparam logic [31:0] OFF_KEYDATA = 32'(NUM_OUT);
    localparam logic [31:0] OFF_KEYSTAT = 32'(NUM_OUT + 1);
    localparam logic [31:0] OFF_FRAME   = 32'(NUM_OUT + 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(KEY_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] addr_ext;
    logic [31:0] offset;
    logic        is_ram;
    logic        io_wr;
    logic        io_rd;
    logic        hit_keydata;
    logic        hit_keystat;
    logic        hit_frame;

    assign addr_ext = 32'(address_dmem);
    assign is_ram   = (addr_ext < BASE);
    assign offset   = addr_ext - BASE;
    assign ram_wren = wren & is_ram;

    // I/O side effects are suppressed while reset is held.
    assign io_wr = wren & ~reset & ~is_ram;
    assign io_rd = rden & ~reset & ~is_ram;

    assign hit_keydata = (offset == OFF_KEYDATA);
    assign hit_keystat = (offset == OFF_KEYSTAT);
    assign hit_frame   = (offset == OFF_FRAME);

    // Only the low channel bits and the overflow-clear bit of store data matter.
    logic unused_data;
    assign unused_data = ^data;

    // ------------------------------------------------------------------
    // Output channels
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] pending_q [NUM_OUT];
    logic [OUT_W-1:0] pending_d [NUM_OUT];
    logic [OUT_W-1:0] visible_q [NUM_OUT];
    logic [OUT_W-1:0] visible_d [NUM_OUT];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_chan
            assign pending_d[gi] = (io_wr && offset == 32'(gi)) ? data[OUT_W-1:0]
                                                                : pending_q[gi];
            // Copy from pending_d so a store in the frame_start cycle makes it
            // into the visible set on that same edge.
            if (SHADOW != 0) begin : g_shadow
                assign visible_d[gi] = frame_start ? pending_d[gi] : visible_q[gi];
            end else begin : g_direct
                assign visible_d[gi] = pending_d[gi];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    pending_q[gi] <= '0;
                    visible_q[gi] <= '0;
                end else begin
                    pending_q[gi] <= pending_d[gi];
                    visible_q[gi] <= visible_d[gi];
                end
            end

            assign chan_out[gi*OUT_W +: OUT_W] = visible_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Keyboard FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [KEY_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             ovf_event;
    logic             ovf_clear;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = io_rd & hit_keydata & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push       = key_valid & (~fifo_full | pop);
    assign ovf_event  = key_valid & fifo_full & ~pop;
    assign ovf_clear  = io_wr & hit_keystat & data[16];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        // Setting beats clearing when both happen in one cycle.
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= key_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] frame_q, frame_d;

    assign frame_d = frame_start ? frame_q + DATA_W'(1) : frame_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Load path: I/O value is registered to line up with RAM latency.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic              sel_ram_q,  sel_ram_d;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (offset == 32'(i)) begin
                rd_val = DATA_W'(pending_q[i]);
            end
        end
        if (hit_keydata && !fifo_empty) begin
            // Bit 8 flags a real byte so software can tell 0x00 from "empty".
            rd_val[8:0] = {1'b1, fifo_mem[rd_ptr_q]};
        end
        if (hit_keystat) begin
            rd_val[16]        = ovf_q;
            rd_val[CNT_W-1:0] = count_q;
        end
        if (hit_frame) begin
            rd_val = frame_q;
        end
    end

    assign io_rdata_d = io_rd ? rd_val : '0;
    assign sel_ram_d  = rden & is_ram;

    always_ff @(posedge clock) begin
        if (reset) begin
            io_rdata_q <= '0;
            sel_ram_q  <= 1'b0;
        end else begin
            io_rdata_q <= io_rdata_d;
            sel_ram_q  <= sel_ram_d;
        end
    end

    assign q_dmem = sel_ram_q ? ram_q : io_rdata_q;

endmodule
